// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_2x2
// Brief    : Streaming 2x2 / stride-2 signed max-pool with a half-width line
//            buffer holding the horizontal maxima of each even row.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_2x2 #(
  parameter int bitwidth  = 8,
  parameter int mapWidth  = 9,
  parameter int mapHeight = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] data_in,
  input  logic                isValid_in,
  output logic [bitwidth-1:0] data_out,
  output logic                isValid_out,
  output logic                frameEnd_out
);

  localparam int outWidth  = mapWidth / 2;
  localparam int outHeight = mapHeight / 2;

  localparam int c_COL_W  = $clog2(mapWidth);
  localparam int c_ROW_W  = $clog2(mapHeight);
  localparam int c_ADDR_W = (outWidth > 1) ? $clog2(outWidth) : 1;

  localparam logic [c_COL_W-1:0] c_COL_LAST     = c_COL_W'(mapWidth - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST     = c_ROW_W'(mapHeight - 1);
  localparam logic [c_COL_W-1:0] c_COL_WIN_LAST = c_COL_W'(2 * outWidth - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_WIN_LAST = c_ROW_W'(2 * outHeight - 1);
  localparam bit                 c_ODD_W        = (mapWidth % 2) != 0;
  localparam bit                 c_ODD_H        = (mapHeight % 2) != 0;

  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [bitwidth-1:0] r_pair;
  logic [bitwidth-1:0] r_line_buf [outWidth];

  logic                w_col_used;
  logic                w_row_used;
  logic [c_ADDR_W-1:0] w_addr;
  logic [bitwidth-1:0] w_hmax;
  logic [bitwidth-1:0] w_vmax;
  logic                w_store_pair;
  logic                w_write_lb;
  logic                w_emit;
  logic                w_last_win;

  function automatic logic [bitwidth-1:0] smax(input logic [bitwidth-1:0] a,
                                               input logic [bitwidth-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // The trailing column/row of an odd-sized map never belongs to a window.
  assign w_col_used = !(c_ODD_W && (r_col == c_COL_LAST));
  assign w_row_used = !(c_ODD_H && (r_row == c_ROW_LAST));

  assign w_addr = c_ADDR_W'(r_col >> 1);
  assign w_hmax = smax(r_pair, data_in);
  assign w_vmax = smax(r_line_buf[w_addr], w_hmax);

  assign w_store_pair = isValid_in && !r_col[0] && w_col_used;
  assign w_write_lb   = isValid_in &&  r_col[0] && !r_row[0] && w_row_used;
  assign w_emit       = isValid_in &&  r_col[0] &&  r_row[0] && w_row_used;
  assign w_last_win   = (r_col == c_COL_WIN_LAST) && (r_row == c_ROW_WIN_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      data_out     <= '0;
      isValid_out  <= 1'b0;
      frameEnd_out <= 1'b0;
    end else begin
      isValid_out  <= 1'b0;
      frameEnd_out <= 1'b0;
      if (isValid_in) begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_store_pair) begin
        r_pair <= data_in;
      end
      if (w_emit) begin
        data_out     <= w_vmax;
        isValid_out  <= 1'b1;
        frameEnd_out <= w_last_win;
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it,
  // so the buffer needs no reset.
  always_ff @(posedge clock) begin
    if (w_write_lb) begin
      r_line_buf[w_addr] <= w_hmax;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_2x2
// Brief    : Self-checking bench for max_pool_2x2 (4x4 and default 9x9 maps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_2x2;

  typedef struct {
    logic [7:0] px;
    bit         out;
    logic [7:0] ev;
    bit         fe;
  } vec_t;

  typedef struct {
    logic [7:0] ev;
    bit         fe;
    longint     cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d4 = '0, d9 = '0;
  logic       v4 = 1'b0, v9 = 1'b0;
  logic [7:0] o4_data, o9_data;
  logic       o4_valid, o9_valid, o4_fe, o9_fe;

  int     checks = 0;
  int     errors = 0;
  int     fe4_cnt = 0;
  int     fe9_cnt = 0;
  longint cyc = 0;
  exp_t   q4[$];
  exp_t   q9[$];
  vec_t   tv[16];

  max_pool_2x2 #(.bitwidth(8), .mapWidth(4), .mapHeight(4)) dut4 (
    .clock(clock), .reset(reset), .data_in(d4), .isValid_in(v4),
    .data_out(o4_data), .isValid_out(o4_valid), .frameEnd_out(o4_fe)
  );

  max_pool_2x2 dut9 (
    .clock(clock), .reset(reset), .data_in(d9), .isValid_in(v9),
    .data_out(o9_data), .isValid_out(o9_valid), .frameEnd_out(o9_fe)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input string tag, input logic [7:0] dat, input logic vld,
                     input logic fe, inout exp_t q[$]);
    exp_t e;
    if (vld) begin
      if (q.size() == 0) begin
        chk({tag, "_unexpected_output"}, longint'($signed(dat)), -999);
      end else begin
        e = q.pop_front();
        chk({tag, "_data"}, longint'($signed(dat)), longint'($signed(e.ev)));
        chk({tag, "_frameEnd"}, longint'(fe), longint'(e.fe));
        chk({tag, "_latency_cycle"}, cyc, e.cyc);
      end
    end else if (fe) begin
      chk({tag, "_frameEnd_without_valid"}, 1, 0);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon("p4", o4_data, o4_valid, o4_fe, q4);
      mon("p9", o9_data, o9_valid, o9_fe, q9);
      if (o4_valid && o4_fe) fe4_cnt++;
      if (o9_valid && o9_fe) fe9_cnt++;
    end
  end

  task automatic send(input bit sel9, input logic [7:0] px, input bit has_exp,
                      input logic [7:0] ev, input bit fe, input int gaps);
    exp_t e;
    @(negedge clock);
    if (sel9) begin d9 = px; v9 = 1'b1; end
    else      begin d4 = px; v4 = 1'b1; end
    if (has_exp) begin
      e.ev = ev; e.fe = fe; e.cyc = cyc + 1;
      if (sel9) q9.push_back(e); else q4.push_back(e);
    end
    for (int g = 0; g < gaps; g++) begin
      @(negedge clock);
      v4 = 1'b0; v9 = 1'b0;
    end
  endtask

  task automatic run_table(input int gaps, input logic [7:0] offset);
    for (int i = 0; i < 16; i++)
      send(1'b0, tv[i].px + offset, tv[i].out, tv[i].ev + offset, tv[i].fe, gaps);
  endtask

  task automatic drain(input string name);
    @(negedge clock);
    v4 = 1'b0; v9 = 1'b0;
    repeat (4) @(negedge clock);
    chk({name, "_p4_pending"}, q4.size(), 0);
    chk({name, "_p9_pending"}, q9.size(), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      tv[i].px  = 8'(i);
      tv[i].out = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv[i].ev  = 8'(i);
      tv[i].fe  = (i == 15);
    end
  endtask

  initial begin
    automatic logic [7:0] spx[16] = '{8'hF8, 8'hFD, 8'hFF, 8'h80,
                                      8'hFB, 8'hF7, 8'hFE, 8'hF9,
                                      8'd4,  8'd3,  8'd0,  8'd1,
                                      8'd2,  8'd6,  8'd0,  8'd0};
    automatic logic [7:0] sexp[4] = '{8'hFD, 8'hFF, 8'd6, 8'd1};
    automatic int k = 0;
    int fe_before;

    // Reset state
    #12;
    chk("rst_p4_data", o4_data, 0);
    chk("rst_p4_valid", o4_valid, 0);
    chk("rst_p4_fe", o4_fe, 0);
    chk("rst_p9_data", o9_data, 0);
    chk("rst_p9_valid", o9_valid, 0);
    chk("rst_p9_fe", o9_fe, 0);
    @(negedge clock);
    reset = 1'b0;

    // 1: ramp 0..15
    fill_ramp();
    run_table(0, 8'd0);
    drain("t1");

    // 2: signed windows
    for (int i = 0; i < 16; i++) begin
      tv[i].px  = spx[i];
      tv[i].out = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tv[i].fe  = (i == 15);
      tv[i].ev  = '0;
      if (tv[i].out) begin tv[i].ev = sexp[k]; k++; end
    end
    run_table(0, 8'd0);
    drain("t2");

    // 3: 9x9, last row/column poisoned with 100
    fe_before = fe9_cnt;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        send(1'b1, (r == 8 || c == 8) ? 8'd100 : 8'd1,
             (r % 2 == 1) && (r < 8) && (c % 2 == 1) && (c < 8),
             8'd1, (r == 7) && (c == 7), 0);
    drain("t3");
    chk("t3_frameEnd_count", fe9_cnt - fe_before, 1);

    // 4: three idle cycles after every pixel
    fill_ramp();
    run_table(3, 8'd0);
    drain("t4");

    // 5: two back-to-back frames
    fe_before = fe4_cnt;
    run_table(0, 8'd0);
    run_table(0, 8'd100);
    drain("t5");
    chk("t5_frameEnd_count", fe4_cnt - fe_before, 2);

    // 6: reset after 6 pixels, the 6th completing a window
    for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 1'b0, 8'd0, 1'b0, 0);
    @(posedge clock);
    #1;
    v4 = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", o4_valid, 0);
    chk("t6_rst_fe", o4_fe, 0);
    chk("t6_rst_data", o4_data, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run_table(0, 8'd0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
